// File: rtl/dpram_arb_pkg.sv
// Shared definitions for the dual-port RAM arbiter.
//   ADDR_W_DEF / DATA_W_DEF / CNT_W_DEF : default address, data and counter widths
//   prio_t : which port wins the next same-address hazard
package dpram_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 3;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned CNT_W_DEF  = 8;

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_t;

endpackage : dpram_arb_pkg

// File: rtl/dual_port_ram.sv
// Simple true dual-port RAM, 2**ADDR_W words of DATA_W bits, synchronous
// read (read-first) and synchronous write on both ports.
//   clk            : clock
//   we_a_i/we_b_i  : write enables
//   addr_a_i/b_i   : addresses
//   data_in_a_i/b_i: write data
//   data_out_a_o/b_o: read data, registered one cycle after the address
// Writing the same address from both ports in one cycle is not resolved
// here; the caller must never do it.
module dual_port_ram #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              we_a_i,
  input  logic [ADDR_W-1:0] addr_a_i,
  input  logic [DATA_W-1:0] data_in_a_i,
  output logic [DATA_W-1:0] data_out_a_o,
  input  logic              we_b_i,
  input  logic [ADDR_W-1:0] addr_b_i,
  input  logic [DATA_W-1:0] data_in_b_i,
  output logic [DATA_W-1:0] data_out_b_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] dout_a_q;
  logic [DATA_W-1:0] dout_b_q;

  // NOTE: the storage array has no reset so it maps onto RAM macros; its
  // contents survive a controller reset.
  always_ff @(posedge clk) begin
    if (we_a_i) mem_q[addr_a_i] <= data_in_a_i;
    if (we_b_i) mem_q[addr_b_i] <= data_in_b_i;
    dout_a_q <= mem_q[addr_a_i];
    dout_b_q <= mem_q[addr_b_i];
  end

  assign data_out_a_o = dout_a_q;
  assign data_out_b_o = dout_b_q;

endmodule : dual_port_ram

// File: rtl/dual_port_ram_arbiter.sv
// Front-end for dual_port_ram: req/gnt handshake per port, same-address
// hazard detection with round-robin serialisation, read-valid strobes and
// a saturating hazard counter.
//   clk, rst (sync, active-high)
//   req_x/we_x/addr_x/wdata_x : request from port x (held until granted)
//   gnt_x                     : combinational grant
//   rvalid_x/rdata_x          : read data, one cycle after a granted read
//   conflict_cnt              : saturating count of hazard (stall) cycles
module dual_port_ram_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic              gnt_a,
  output logic              rvalid_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              gnt_b,
  output logic              rvalid_b,
  output logic [DATA_W-1:0] rdata_b,
  output logic [CNT_W-1:0]  conflict_cnt
);

  prio_t             prio_q, prio_d;
  logic              rvalid_a_q, rvalid_a_d;
  logic              rvalid_b_q, rvalid_b_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              hazard;
  logic              xfer_a, xfer_b;

  // A read-read on the same address is harmless; anything involving a write
  // must be serialised. Reset masks the hazard so nothing is counted or
  // rotated while the block is held in reset.
  assign hazard = !rst && req_a && req_b && (addr_a == addr_b) && (we_a || we_b);

  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    gnt_a      = 1'b0;
    gnt_b      = 1'b0;
    prio_d     = prio_q;
    cnt_d      = cnt_q;
    if (!rst) begin
      if (hazard) begin
        gnt_a  = (prio_q == PRIO_A);
        gnt_b  = (prio_q == PRIO_B);
        // The loser gets priority, so it wins the very next cycle.
        prio_d = (prio_q == PRIO_A) ? PRIO_B : PRIO_A;
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
      end else begin
        gnt_a  = req_a;
        gnt_b  = req_b;
      end
    end
  end

  assign xfer_a     = req_a && gnt_a;
  assign xfer_b     = req_b && gnt_b;
  assign rvalid_a_d = xfer_a && !we_a;
  assign rvalid_b_d = xfer_b && !we_b;

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q     <= PRIO_A;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      prio_q     <= prio_d;
      rvalid_a_q <= rvalid_a_d;
      rvalid_b_q <= rvalid_b_d;
      cnt_q      <= cnt_d;
    end
  end

  dual_port_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk          (clk),
    .we_a_i       (xfer_a && we_a),
    .addr_a_i     (addr_a),
    .data_in_a_i  (wdata_a),
    .data_out_a_o (rdata_a),
    .we_b_i       (xfer_b && we_b),
    .addr_b_i     (addr_b),
    .data_in_b_i  (wdata_b),
    .data_out_b_o (rdata_b)
  );

  assign rvalid_a     = rvalid_a_q;
  assign rvalid_b     = rvalid_b_q;
  assign conflict_cnt = cnt_q;

endmodule : dual_port_ram_arbiter

// File: doc/dual_port_ram_arbiter.md
# dual_port_ram_arbiter

Front-end controller for `dual_port_ram` (8 x 8-bit, synchronous). It gives two independent requesters a req/gnt handshake onto ports A and B. It detects same-address hazards (write-write, read-write) and serialises them with round-robin priority, so no request starves. It also produces read-valid strobes and a saturating conflict counter for debug.

## Interface
Parameters:
- ADDR_W, 3, RAM address width (depth = 2**ADDR_W)
- DATA_W, 8, RAM data width
- CNT_W, 8, width of conflict counter

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_a  in  1  port A request; held high until granted
- we_a  in  1  port A write (1) / read (0); stable while req_a high
- addr_a  in  ADDR_W  port A address
- wdata_a  in  DATA_W  port A write data
- gnt_a  out  1  port A granted this cycle (combinational)
- rvalid_a  out  1  rdata_a valid (one cycle after a granted read)
- rdata_a  out  DATA_W  port A read data
- req_b, we_b, addr_b, wdata_b, gnt_b, rvalid_b, rdata_b: same as port A, for port B
- conflict_cnt  out  CNT_W  count of cycles in which a hazard forced a stall (saturating)

## Operation
- Transfer on a port occurs in a cycle where req_x && gnt_x. A write commits at that clock edge; a read launches at that edge.
- Hazard is defined as: req_a && req_b && addr_a == addr_b && (we_a || we_b). Read-read on the same address is not a hazard.
- No hazard: gnt_x = req_x for both ports, so both transfer in the same cycle.
- Hazard: exactly one port is granted, chosen by priority pointer `prio` (0 = A, 1 = B). The other port's gnt is 0 and it must hold req and its fields.
- `prio` update: on every hazard cycle it flips to the loser, so the loser wins the next cycle. With no hazard, `prio` holds.
- The RAM is driven with we_x_ram = req_x && gnt_x && we_x. Address and data pass straight through from the inputs.
- rvalid_x is registered: rvalid_x <= req_x && gnt_x && !we_x.
- rdata_x is the RAM data_out_x. It is valid only while rvalid_x = 1 and is undefined otherwise.
- conflict_cnt increments by 1 on each hazard cycle and saturates at 2**CNT_W-1.

## Timing
- Grant latency: 0 cycles with no hazard. Under a sustained hazard, the worst case is 1 stall cycle per port.
- Read latency: rvalid_x and rdata_x appear 1 cycle after the granted cycle.
- Back-to-back transfers: a port may be granted every cycle.
- Values while rst = 1 and after reset: gnt_a = gnt_b = 0, rvalid_a = rvalid_b = 0, prio = 0 (A), conflict_cnt = 0.
- Reset mid-operation: all requests in flight are dropped and no RAM write is issued during the reset cycle. RAM contents are not cleared.
- Same-cycle write on A and read on B to different addresses: both are granted. The read returns the pre-existing contents of B's address.
- A port with req_x = 0 never receives a grant, and req_x = 0 never affects `prio`.

## Structure
- Package `dpram_arb_pkg`:
  - default ADDR_W and DATA_W constants
  - `prio_t` enum {PRIO_A, PRIO_B}
- Sub-module: the existing `dual_port_ram`, instantiated once and unmodified.
- Arbitration logic is inline: a hazard comparator, the grant logic, a 1-bit `prio` register, rvalid flops and the counter. No further sub-modules.

## Test plan
- Reset check: hold rst = 1 for 3 cycles with req_a = req_b = 1. Required: gnt = 0, rvalid = 0, conflict_cnt = 0 throughout, and no RAM write.
- Parallel writes: A writes 0xAA to addr 0 and B writes 0xBB to addr 1 in the same cycle. Required: both gnt = 1 and conflict_cnt stays 0. Then A reads 0 and B reads 1 in the same cycle. Required: rvalid_a = rvalid_b = 1 next cycle, with rdata_a = 0xAA and rdata_b = 0xBB.
- Write-write hazard: both ports write addr 3 (A 0x11, B 0x22) after reset. Required:
  - cycle 1: gnt_a = 1, gnt_b = 0;
  - cycle 2: gnt_b = 1;
  - a later read of addr 3 returns 0x22 and conflict_cnt = 1.
- Read-write hazard: A reads addr 5 while B writes 0x5C to addr 5, with prio = B. Required: B is granted first. A is granted next cycle and gets rvalid_a with rdata_a = 0x5C.
- Fairness: hold a same-address write-write hazard for 6 cycles with both ports re-requesting immediately. Required: grants alternate A, B, A, B… and conflict_cnt = 6.
- Saturation and read-read: force 300 hazard cycles. Required: conflict_cnt = 255 and holds there. Then A and B both read addr 2 in the same cycle. Required: both granted and conflict_cnt remains 255.
